// File: rtl/sprite_queue_if.sv
// sprite_queue_if -- bundles the writer, reader and status signals of the
// sprite command queue.
//
//   master : the side that pushes/pops commands (frame builder / renderer)
//            drives clear, enqueue, in_sprite_*, sprite_queue_dequeue and
//            observes status and the head entry.
//   slave  : the queue itself.
//
// Parameter DEPTH must match the DEPTH of the sprite_queue instance; it sizes
// the count field ($clog2(DEPTH)+1 bits so that a full queue is representable).
interface sprite_queue_if #(
    parameter int DEPTH = 32
);
    localparam int CW = $clog2(DEPTH) + 1;

    // writer side
    logic          clear;
    logic          enqueue;
    logic [7:0]    in_sprite_id;
    logic [15:0]   in_sprite_x;
    logic [15:0]   in_sprite_y;
    logic [7:0]    in_sprite_scale;
    logic          is_full;
    logic          overflow;
    logic [CW-1:0] count;
    logic [7:0]    drop_count;

    // reader side
    logic          sprite_queue_dequeue;
    logic          sprite_queue_is_empty;
    logic [7:0]    sprite_queue_sprite_id;
    logic [15:0]   sprite_queue_sprite_x;
    logic [15:0]   sprite_queue_sprite_y;
    logic [7:0]    sprite_queue_sprite_scale;

    modport master (
        output clear, enqueue, in_sprite_id, in_sprite_x, in_sprite_y,
               in_sprite_scale, sprite_queue_dequeue,
        input  is_full, overflow, count, drop_count, sprite_queue_is_empty,
               sprite_queue_sprite_id, sprite_queue_sprite_x,
               sprite_queue_sprite_y, sprite_queue_sprite_scale
    );

    modport slave (
        input  clear, enqueue, in_sprite_id, in_sprite_x, in_sprite_y,
               in_sprite_scale, sprite_queue_dequeue,
        output is_full, overflow, count, drop_count, sprite_queue_is_empty,
               sprite_queue_sprite_id, sprite_queue_sprite_x,
               sprite_queue_sprite_y, sprite_queue_sprite_scale
    );
endinterface

// File: rtl/sprite_queue.sv
// sprite_queue -- circular FIFO of sprite draw commands {id, x, y, scale}
// with a show-ahead read port.
//
// Ports:
//   clock : system clock, all state updates on its rising edge
//   reset : synchronous active-high reset (highest priority)
//   bus   : sprite_queue_if.slave
//           clear                  flush all entries (frame start)
//           enqueue / in_sprite_*  push one command
//           sprite_queue_dequeue   pop the head command
//           sprite_queue_sprite_*  head command, 0 while empty
//           count / is_full / sprite_queue_is_empty  registered status
//           overflow               sticky: an enqueue was dropped
//           drop_count             saturating count of dropped enqueues
//
// Parameter DEPTH: number of entries, power of two in 2..256.
//
// Build option: define SPRITE_QUEUE_DROP_CNT_EN to build the 8-bit saturating
// drop counter; otherwise drop_count is constant 0.
module sprite_queue #(
    parameter int DEPTH = 32
) (
    input logic         clock,
    input logic         reset,
    sprite_queue_if.slave bus
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    typedef struct packed {
        logic [7:0]  id;
        logic [15:0] x;
        logic [15:0] y;
        logic [7:0]  scale;
    } entry_t;

    typedef enum logic [1:0] {
        ST_EMPTY,
        ST_ACTIVE,
        ST_FULL
    } state_e;

    entry_t        mem_q [DEPTH];
    entry_t        head;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          overflow_q, overflow_d;
    state_e        state_q, state_d;

    logic          do_deq;
    logic          acc_enq;
    logic          drop;

    // ------------------------------------------------------------------
    // Request qualification. A full queue still accepts a push when a pop
    // happens in the same cycle, because the pop frees the slot.
    // ------------------------------------------------------------------
    always_comb begin
        do_deq  = bus.sprite_queue_dequeue && (count_q != '0);
        acc_enq = bus.enqueue && ((count_q != DEPTH_C) || bus.sprite_queue_dequeue);
        drop    = bus.enqueue && (count_q == DEPTH_C) && !bus.sprite_queue_dequeue;
    end

    // ------------------------------------------------------------------
    // Pointer / count / overflow next state. clear wins over push and pop
    // and never raises overflow.
    // ------------------------------------------------------------------
    always_comb begin
        // NOTE: every combinational output gets a default first so no path
        // leaves it unassigned; a missing default infers a latch.
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q;
        if (bus.clear) begin
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            count_d    = '0;
            overflow_d = 1'b0;
        end else begin
            // pointers are exactly AW bits wide, so DEPTH-1 wraps to 0
            if (acc_enq) wr_ptr_d = wr_ptr_q + AW'(1);
            if (do_deq)  rd_ptr_d = rd_ptr_q + AW'(1);
            count_d = count_q + CW'(acc_enq) - CW'(do_deq);
            if (drop) overflow_d = 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        // NOTE: state registers use non-blocking assignments so every flop
        // samples its pre-edge inputs regardless of statement order.
        if (reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    // NOTE: storage is deliberately not reset; entries are only observable
    // through rd_ptr/count, which are, and this keeps the array RAM-mappable.
    always_ff @(posedge clock) begin
        if (acc_enq) begin
            mem_q[wr_ptr_q] <= '{id:    bus.in_sprite_id,
                                 x:     bus.in_sprite_x,
                                 y:     bus.in_sprite_y,
                                 scale: bus.in_sprite_scale};
        end
    end

    // ------------------------------------------------------------------
    // Occupancy FSM: state register / next state / outputs.
    // ------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (reset) state_q <= ST_EMPTY;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (bus.clear) begin
            state_d = ST_EMPTY;
        end else begin
            case (state_q)
                ST_EMPTY:  if (acc_enq) state_d = (count_d == DEPTH_C) ? ST_FULL : ST_ACTIVE;
                ST_ACTIVE: begin
                    if (count_d == DEPTH_C)  state_d = ST_FULL;
                    else if (count_d == '0)  state_d = ST_EMPTY;
                end
                ST_FULL:   if (do_deq && !acc_enq) state_d = ST_ACTIVE;
                default:   state_d = ST_EMPTY;
            endcase
        end
    end

    // Status flags come straight from the registered state, so they always
    // agree with count_q. The head entry is forced to 0 while empty so stale
    // storage never leaks out.
    always_comb begin
        head                          = mem_q[rd_ptr_q];
        bus.is_full                   = (state_q == ST_FULL);
        bus.sprite_queue_is_empty     = (state_q == ST_EMPTY);
        bus.count                     = count_q;
        bus.overflow                  = overflow_q;
        bus.sprite_queue_sprite_id    = '0;
        bus.sprite_queue_sprite_x     = '0;
        bus.sprite_queue_sprite_y     = '0;
        bus.sprite_queue_sprite_scale = '0;
        if (state_q != ST_EMPTY) begin
            bus.sprite_queue_sprite_id    = head.id;
            bus.sprite_queue_sprite_x     = head.x;
            bus.sprite_queue_sprite_y     = head.y;
            bus.sprite_queue_sprite_scale = head.scale;
        end
    end

    // ------------------------------------------------------------------
    // Optional dropped-enqueue counter, saturating at 255.
    // ------------------------------------------------------------------
`ifdef SPRITE_QUEUE_DROP_CNT_EN
    logic [7:0] drop_cnt_q, drop_cnt_d;

    always_comb begin
        drop_cnt_d = drop_cnt_q;
        if (bus.clear)                          drop_cnt_d = '0;
        else if (drop && (drop_cnt_q != 8'hFF)) drop_cnt_d = drop_cnt_q + 8'd1;
    end

    always_ff @(posedge clock) begin
        if (reset) drop_cnt_q <= '0;
        else       drop_cnt_q <= drop_cnt_d;
    end

    assign bus.drop_count = drop_cnt_q;
`else
    assign bus.drop_count = '0;
`endif

endmodule
